data_memory_block: RTL and testbench

- Main data-memory responder behind the L1 data cache. Serves 128-bit block reads and write-backs on the cache's block-transfer interface: READ/WRITE strobes, 28-bit block address, 128-bit data, BUSY_WAIT handshake.
- Emulates DRAM with a programmable fixed latency.
- Sits at the bottom of the data-memory path in the RV32IM pipeline.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/data_memory_block_if.sv | 51 +++++
 rtl/dmem_storage_array.sv | 51 +++++
 rtl/data_memory_block.sv | 186 ++++++++++++++++++
 tb/tb_data_memory_block.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the main data-memory responder and the L1 data
// cache that talks to it.
//   BLOCK_WIDTH    : width of one cache block / memory word (128 bits)
//   MEM_ADDR_WIDTH : width of the block address driven by the cache
//   COUNT_WIDTH    : width of the latency counter in the responder
//   dmem_state_t   : responder FSM encoding (IDLE/BUSY/DONE)
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int BLOCK_WIDTH    = 128;
    localparam int MEM_ADDR_WIDTH = 28;
    localparam int COUNT_WIDTH    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/data_memory_block_if.sv
// ---------------------------------------------------------------------------
// data_memory_block_if
// Block-transfer bus between the L1 data cache (master) and the main data
// memory (slave).
//   READ, WRITE  : request strobes from the cache
//   ADDRESS      : block address {tag, index}
//   WRITE_DATA   : block to write
//   READ_DATA    : registered block read result
//   BUSY_WAIT    : responder busy
//   ERROR        : sticky protocol-error flag
//
// Handshake: the cache raises READ or WRITE together with ADDRESS and
// WRITE_DATA and holds them until it samples BUSY_WAIT low. BUSY_WAIT goes
// high combinationally in the same cycle as the request and stays high until
// the transaction has completed; the single cycle with BUSY_WAIT low marks
// completion (READ_DATA valid for a read, memory updated for a write). The
// responder ignores the strobes in that completion cycle; a strobe still
// high in the following cycle is taken as a new request.
// ---------------------------------------------------------------------------
interface data_memory_block_if;
    import dmem_pkg::*;

    logic                      READ;
    logic                      WRITE;
    logic [MEM_ADDR_WIDTH-1:0] ADDRESS;
    logic [BLOCK_WIDTH-1:0]    WRITE_DATA;
    logic [BLOCK_WIDTH-1:0]    READ_DATA;
    logic                      BUSY_WAIT;
    logic                      ERROR;

    modport master (
        output READ,
        output WRITE,
        output ADDRESS,
        output WRITE_DATA,
        input  READ_DATA,
        input  BUSY_WAIT,
        input  ERROR
    );

    modport slave (
        input  READ,
        input  WRITE,
        input  ADDRESS,
        input  WRITE_DATA,
        output READ_DATA,
        output BUSY_WAIT,
        output ERROR
    );

endinterface

// File: rtl/dmem_storage_array.sv
// ---------------------------------------------------------------------------
// dmem_storage_array
// Single-port synchronous RAM, 2**ADDR_BITS blocks of BLOCK_WIDTH bits.
//   i_clk     : clock
//   i_rst_n   : synchronous active-low reset; clears only the read register,
//               never the array contents
//   i_we      : write enable, i_wdata -> mem[i_addr]
//   i_re      : read enable, mem[i_addr] -> o_rdata on the same edge
//   i_rd_zero : force the read result to zero (out-of-range read)
//   i_addr    : block index
//   i_wdata   : write block
//   o_rdata   : registered read block, held until the next read
// ---------------------------------------------------------------------------
module dmem_storage_array
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_we,
    input  logic                   i_re,
    input  logic                   i_rd_zero,
    input  logic [ADDR_BITS-1:0]   i_addr,
    input  logic [BLOCK_WIDTH-1:0] i_wdata,
    output logic [BLOCK_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [BLOCK_WIDTH-1:0] r_mem [DEPTH];
    logic [BLOCK_WIDTH-1:0] r_rdata;

    // Array contents have no reset; they survive RESET_N like real DRAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rd_zero ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_block.sv
// ---------------------------------------------------------------------------
// data_memory_block
// Main data-memory responder behind the L1 data cache. Serves 128-bit block
// reads and write-backs with a fixed, programmable latency that emulates DRAM.
//
// Parameters:
//   ADDR_BITS : block-address bits decoded; depth = 2**ADDR_BITS blocks
//   LATENCY   : cycles spent in BUSY per transaction (1..255)
//
// Ports:
//   CLK     : clock, all state updates on the rising edge
//   RESET_N : synchronous active-low reset
//   bus     : block-transfer bus (slave side): READ, WRITE, ADDRESS,
//             WRITE_DATA in; READ_DATA, BUSY_WAIT, ERROR out
//   o_state : current FSM state, for debug and checkers
//
// Optional build macro DMEM_ERR_CHECK_EN: when defined, ERROR is set (sticky
// until reset) for a request with both strobes high or with address bits
// above ADDR_BITS-1 set; out-of-range reads return zero and out-of-range
// writes are discarded. When undefined, ERROR is tied low and the upper
// address bits simply alias.
//
// Timing: a request first high in cycle 0 is accepted on the edge closing
// cycle 0, spends LATENCY cycles in BUSY, and BUSY_WAIT is low in cycle
// LATENCY+1 (the DONE cycle).
// ---------------------------------------------------------------------------
module data_memory_block
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 5
) (
    input  logic                CLK,
    input  logic                RESET_N,
    data_memory_block_if.slave  bus,
    output dmem_state_t         o_state
);

    localparam logic [COUNT_WIDTH-1:0] LAT_LOAD = COUNT_WIDTH'(LATENCY - 1);

    dmem_state_t            r_state;
    dmem_state_t            w_next_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [BLOCK_WIDTH-1:0] r_wdata;
    logic                   r_is_write;
    logic                   r_oor;

    logic                   w_req;
    logic                   w_accept;
    logic                   w_req_oor;
    logic                   w_busy;
    logic                   w_mem_we;
    logic                   w_mem_re;
    logic [BLOCK_WIDTH-1:0] w_rdata;

    assign w_req    = bus.READ | bus.WRITE;
    assign w_accept = (r_state == ST_IDLE) && w_req;

`ifdef DMEM_ERR_CHECK_EN
    logic r_error;
    logic w_req_err;

    // Any address bit above the decoded range marks the request out of range.
    assign w_req_oor = (bus.ADDRESS >> ADDR_BITS) != '0;
    assign w_req_err = (bus.READ & bus.WRITE) | w_req_oor;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_error <= 1'b0;
        end else if (w_accept && w_req_err) begin
            r_error <= 1'b1;
        end
    end

    assign bus.ERROR = r_error;
`else
    // Upper address bits alias onto the decoded range.
    logic w_unused_addr;

    assign w_req_oor     = 1'b0;
    assign w_unused_addr = |bus.ADDRESS;
    assign bus.ERROR     = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_count == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            // Strobes seen in DONE belong to the transaction just finished.
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_busy   = 1'b0;
        w_mem_we = 1'b0;
        w_mem_re = 1'b0;
        case (r_state)
            // Combinational busy so the cache never sees a false low in the
            // first cycle of its request.
            ST_IDLE: w_busy = w_req;
            ST_BUSY: begin
                w_busy = 1'b1;
                if (r_count == '0) begin
                    w_mem_we = r_is_write & ~r_oor;
                    w_mem_re = ~r_is_write;
                end
            end
            ST_DONE: w_busy = 1'b0;
            default: w_busy = 1'b0;
        endcase
    end

    assign bus.BUSY_WAIT = RESET_N & w_busy;
    assign o_state       = r_state;

    // -----------------------------------------------------------------------
    // Latency counter and latched request operands. Operands are captured
    // once at acceptance so later bus changes cannot disturb the transaction.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_count    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_oor      <= 1'b0;
        end else if (w_accept) begin
            r_count    <= LAT_LOAD;
            r_addr     <= bus.ADDRESS[ADDR_BITS-1:0];
            r_wdata    <= bus.WRITE_DATA;
            r_is_write <= bus.WRITE;    // WRITE wins when both strobes are high
            r_oor      <= w_req_oor;
        end else if ((r_state == ST_BUSY) && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Storage. The write enable is gated by RESET_N so a write whose commit
    // edge coincides with reset is dropped.
    // -----------------------------------------------------------------------
    dmem_storage_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_storage (
        .i_clk     (CLK),
        .i_rst_n   (RESET_N),
        .i_we      (w_mem_we & RESET_N),
        .i_re      (w_mem_re),
        .i_rd_zero (r_oor),
        .i_addr    (r_addr),
        .i_wdata   (r_wdata),
        .o_rdata   (w_rdata)
    );

    assign bus.READ_DATA = w_rdata;

endmodule

// File: tb/tb_data_memory_block.sv
// ---------------------------------------------------------------------------
// tb_data_memory_block
// Self-checking bench for data_memory_block (ADDR_BITS=8, LATENCY=5).
// A reference memory array and a simple latency rule (completion in cycle
// LATENCY+1 after the request) provide every expected value.
// ---------------------------------------------------------------------------
module tb_data_memory_block;
    import dmem_pkg::*;

    localparam int ADDR_BITS = 8;
    localparam int LATENCY   = 5;
    localparam int DEPTH     = 256;
    localparam int EXP_LAT   = LATENCY + 1;
    localparam int PERIOD    = LATENCY + 2;

    logic        CLK;
    logic        RESET_N;
    dmem_state_t o_state;

    data_memory_block_if bus();

    data_memory_block #(
        .ADDR_BITS (ADDR_BITS),
        .LATENCY   (LATENCY)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus),
        .o_state (o_state)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    logic [BLOCK_WIDTH-1:0] ref_mem [DEPTH];
    logic [BLOCK_WIDTH-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic int blk(input logic [27:0] a);
        return int'({4'b0, a}) % DEPTH;
    endfunction

    function automatic logic [BLOCK_WIDTH-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks. Called just after a rising edge with the DUT idle;
    // return just after a rising edge with the DUT idle and strobes low.
    // mut_cyc >= 1 disturbs the bus in that cycle: drop the strobes
    // (mut_drop) or scramble ADDRESS/WRITE_DATA.
    // ------------------------------------------------------------------
    task automatic do_txn(input bit rd, input bit wr, input logic [27:0] addr,
                          input logic [BLOCK_WIDTH-1:0] data, input int mut_cyc,
                          input bit mut_drop, output int lat,
                          output logic [BLOCK_WIDTH-1:0] rdata);
        bus.READ       = rd;
        bus.WRITE      = wr;
        bus.ADDRESS    = addr;
        bus.WRITE_DATA = data;
        lat   = -1;
        rdata = '0;
        for (int c = 0; c < 64; c++) begin
            if (c == mut_cyc) begin
                if (mut_drop) begin
                    bus.READ  = 1'b0;
                    bus.WRITE = 1'b0;
                end else begin
                    bus.ADDRESS    = 28'($urandom);
                    bus.WRITE_DATA = rand_block();
                end
            end
            @(negedge CLK);
            if (!bus.BUSY_WAIT) begin
                lat   = c;
                rdata = bus.READ_DATA;
                break;
            end
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    task automatic apply_reset();
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic init_memory();
        int lat;
        logic [BLOCK_WIDTH-1:0] rd;
        for (int i = 0; i < DEPTH; i++) begin
            do_txn(1'b0, 1'b1, 28'(i), '0, -1, 1'b0, lat, rd);
            ref_mem[i] = '0;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        RESET_N        = 1'b0;
        bus.READ       = 1'b1;
        bus.WRITE      = 1'b0;
        bus.ADDRESS    = 28'h0;
        bus.WRITE_DATA = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            n_checks++;
            if (bus.BUSY_WAIT !== 1'b0)
                $display("FAIL rst_busy%0d: got %b exp 0", i, bus.BUSY_WAIT);
            else n_pass++;
        end
        n_checks++;
        if (bus.READ_DATA !== '0) $display("FAIL rst_rdata: got %h exp 0", bus.READ_DATA);
        else n_pass++;
        n_checks++;
        if (bus.ERROR !== 1'b0) $display("FAIL rst_error: got %b exp 0", bus.ERROR);
        else n_pass++;
        @(posedge CLK);
        #1;
        RESET_N  = 1'b1;
        bus.READ = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (o_state !== ST_IDLE) $display("FAIL rst_state: got %0d exp %0d", o_state, ST_IDLE);
        else n_pass++;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_write_read();
        int lat;
        logic [BLOCK_WIDTH-1:0] rd;
        logic [BLOCK_WIDTH-1:0] d = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBABE;
        do_txn(1'b0, 1'b1, 28'h05, d, -1, 1'b0, lat, rd);
        ref_mem[blk(28'h05)] = d;
        n_checks++;
        if (lat !== EXP_LAT) $display("FAIL wr_latency: got %0d exp %0d", lat, EXP_LAT);
        else n_pass++;
        exp_q.push_back(ref_mem[blk(28'h05)]);
        do_txn(1'b1, 1'b0, 28'h05, '0, -1, 1'b0, lat, rd);
        n_checks++;
        if (lat !== EXP_LAT) $display("FAIL rd_latency: got %0d exp %0d", lat, EXP_LAT);
        else n_pass++;
        n_checks++;
        if (rd !== exp_q[0]) $display("FAIL raw_data: got %h exp %h", rd, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_back_to_back();
        int lat;
        int lows[$];
        logic [BLOCK_WIDTH-1:0] rd;
        logic [BLOCK_WIDTH-1:0] d = rand_block();
        do_txn(1'b0, 1'b1, 28'h0A, d, -1, 1'b0, lat, rd);
        ref_mem[blk(28'h0A)] = d;
        bus.READ    = 1'b1;
        bus.ADDRESS = 28'h0A;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            @(negedge CLK);
            if (!bus.BUSY_WAIT) begin
                lows.push_back(c);
                n_checks++;
                if (bus.READ_DATA !== ref_mem[blk(28'h0A)])
                    $display("FAIL b2b_data@%0d: got %h exp %h", c, bus.READ_DATA, ref_mem[blk(28'h0A)]);
                else n_pass++;
            end
            @(posedge CLK);
            #1;
        end
        bus.READ = 1'b0;
        @(posedge CLK);
        #1;
        n_checks++;
        if (lows.size() !== 3) $display("FAIL b2b_count: got %0d exp 3", lows.size());
        else n_pass++;
        for (int k = 0; k < lows.size() && k < 3; k++) begin
            n_checks++;
            if (lows[k] !== k * PERIOD + EXP_LAT)
                $display("FAIL b2b_slot%0d: got %0d exp %0d", k, lows[k], k * PERIOD + EXP_LAT);
            else n_pass++;
        end
    endtask

    task automatic test_addr_change();
        int lat;
        logic [BLOCK_WIDTH-1:0] rd;
        logic [BLOCK_WIDTH-1:0] d = rand_block();
        // Accepted at the end of cycle 0; bus scrambled in cycle 2.
        do_txn(1'b0, 1'b1, 28'h01, d, 2, 1'b0, lat, rd);
        ref_mem[blk(28'h01)] = d;
        do_txn(1'b1, 1'b0, 28'h01, '0, -1, 1'b0, lat, rd);
        n_checks++;
        if (rd !== ref_mem[1]) $display("FAIL latch_mem1: got %h exp %h", rd, ref_mem[1]);
        else n_pass++;
        do_txn(1'b1, 1'b0, 28'h02, '0, -1, 1'b0, lat, rd);
        n_checks++;
        if (rd !== ref_mem[2]) $display("FAIL latch_mem2: got %h exp %h", rd, ref_mem[2]);
        else n_pass++;
        // Write withdrawn mid-BUSY still commits.
        d = rand_block();
        do_txn(1'b0, 1'b1, 28'h03, d, 3, 1'b1, lat, rd);
        ref_mem[3] = d;
        n_checks++;
        if (lat !== EXP_LAT) $display("FAIL withdraw_lat: got %0d exp %0d", lat, EXP_LAT);
        else n_pass++;
        do_txn(1'b1, 1'b0, 28'h03, '0, -1, 1'b0, lat, rd);
        n_checks++;
        if (rd !== ref_mem[3]) $display("FAIL withdraw_data: got %h exp %h", rd, ref_mem[3]);
        else n_pass++;
    endtask

    // Reset in BUSY cycle 3, then on the commit edge itself (cycle LATENCY).
    task automatic test_reset_mid_op();
        int lat;
        int rst_cyc[2] = '{3, LATENCY};
        logic [27:0] a;
        logic [BLOCK_WIDTH-1:0] rd;
        for (int k = 0; k < 2; k++) begin
            a = 28'h07 + 28'(k);
            bus.WRITE      = 1'b1;
            bus.ADDRESS    = a;
            bus.WRITE_DATA = rand_block();
            repeat (rst_cyc[k]) begin
                @(posedge CLK);
                #1;
            end
            RESET_N   = 1'b0;
            bus.WRITE = 1'b0;
            @(negedge CLK);
            n_checks++;
            if (bus.BUSY_WAIT !== 1'b0) $display("FAIL midrst_busy%0d: got %b exp 0", k, bus.BUSY_WAIT);
            else n_pass++;
            @(posedge CLK);
            #1;
            RESET_N = 1'b1;
            @(negedge CLK);
            n_checks++;
            if (o_state !== ST_IDLE) $display("FAIL midrst_state%0d: got %0d exp %0d", k, o_state, ST_IDLE);
            else n_pass++;
            n_checks++;
            if (bus.READ_DATA !== '0) $display("FAIL midrst_rdata%0d: got %h exp 0", k, bus.READ_DATA);
            else n_pass++;
            @(posedge CLK);
            #1;
            do_txn(1'b1, 1'b0, a, '0, -1, 1'b0, lat, rd);
            n_checks++;
            if (rd !== ref_mem[blk(a)]) $display("FAIL midrst_mem%0d: got %h exp %h", k, rd, ref_mem[blk(a)]);
            else n_pass++;
        end
    endtask

    task automatic test_range();
        int lat;
        logic [BLOCK_WIDTH-1:0] rd;
        logic [BLOCK_WIDTH-1:0] d  = rand_block();
        logic [BLOCK_WIDTH-1:0] d2 = rand_block();
`ifdef DMEM_ERR_CHECK_EN
        do_txn(1'b0, 1'b1, 28'h100, d, -1, 1'b0, lat, rd);
        n_checks++;
        if (bus.ERROR !== 1'b1) $display("FAIL err_oor_flag: got %b exp 1", bus.ERROR);
        else n_pass++;
        do_txn(1'b1, 1'b0, 28'h100, '0, -1, 1'b0, lat, rd);
        n_checks++;
        if (rd !== '0) $display("FAIL err_oor_read: got %h exp 0", rd);
        else n_pass++;
        do_txn(1'b1, 1'b0, 28'h000, '0, -1, 1'b0, lat, rd);
        n_checks++;
        if (rd !== ref_mem[0]) $display("FAIL err_oor_wr_dropped: got %h exp %h", rd, ref_mem[0]);
        else n_pass++;
        n_checks++;
        if (bus.ERROR !== 1'b1) $display("FAIL err_sticky: got %b exp 1", bus.ERROR);
        else n_pass++;
        apply_reset();
        n_checks++;
        if (bus.ERROR !== 1'b0) $display("FAIL err_cleared: got %b exp 0", bus.ERROR);
        else n_pass++;
        do_txn(1'b1, 1'b1, 28'h03, d2, -1, 1'b0, lat, rd);
        ref_mem[3] = d2;
        n_checks++;
        if (bus.ERROR !== 1'b1) $display("FAIL err_both_flag: got %b exp 1", bus.ERROR);
        else n_pass++;
        apply_reset();
`else
        do_txn(1'b0, 1'b1, 28'h100, d, -1, 1'b0, lat, rd);
        ref_mem[blk(28'h100)] = d;
        n_checks++;
        if (bus.ERROR !== 1'b0) $display("FAIL alias_error: got %b exp 0", bus.ERROR);
        else n_pass++;
        do_txn(1'b1, 1'b0, 28'h000, '0, -1, 1'b0, lat, rd);
        n_checks++;
        if (rd !== ref_mem[0]) $display("FAIL alias_read: got %h exp %h", rd, ref_mem[0]);
        else n_pass++;
        do_txn(1'b1, 1'b1, 28'h03, d2, -1, 1'b0, lat, rd);
        ref_mem[3] = d2;
        n_checks++;
        if (bus.ERROR !== 1'b0) $display("FAIL both_error: got %b exp 0", bus.ERROR);
        else n_pass++;
`endif
        do_txn(1'b1, 1'b0, 28'h03, '0, -1, 1'b0, lat, rd);
        n_checks++;
        if (rd !== ref_mem[3]) $display("FAIL both_is_write: got %h exp %h", rd, ref_mem[3]);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat;
        int mc;
        bit is_wr;
        bit md;
        logic [27:0] a;
        logic [BLOCK_WIDTH-1:0] d;
        logic [BLOCK_WIDTH-1:0] rd;
        logic [BLOCK_WIDTH-1:0] exp;
        logic [BLOCK_WIDTH-1:0] last_rd;
        do_txn(1'b1, 1'b0, 28'h0, '0, -1, 1'b0, lat, rd);
        last_rd = ref_mem[0];
        for (int n = 0; n < 40; n++) begin
            is_wr = 1'($urandom_range(0, 1));
            a     = 28'($urandom_range(0, DEPTH - 1));
`ifndef DMEM_ERR_CHECK_EN
            if ($urandom_range(0, 3) == 0) a = a + 28'(DEPTH * $urandom_range(1, 1000));
`endif
            d  = rand_block();
            mc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, LATENCY) : -1;
            md = 1'($urandom_range(0, 1));
            if (!is_wr) exp_q.push_back(ref_mem[blk(a)]);
            do_txn(!is_wr, is_wr, a, d, mc, md, lat, rd);
            n_checks++;
            if (lat !== EXP_LAT) $display("FAIL rnd_lat%0d: got %0d exp %0d", n, lat, EXP_LAT);
            else n_pass++;
            if (is_wr) begin
                ref_mem[blk(a)] = d;
                n_checks++;
                if (rd !== last_rd) $display("FAIL rnd_hold%0d: got %h exp %h", n, rd, last_rd);
                else n_pass++;
            end else begin
                exp = exp_q.pop_front();
                last_rd = exp;
                n_checks++;
                if (rd !== exp) $display("FAIL rnd_rd%0d: got %h exp %h", n, rd, exp);
                else n_pass++;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and final report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        init_memory();
        test_write_read();
        test_back_to_back();
        test_addr_change();
        test_reset_mid_op();
        test_range();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
